cmd_card_responder: RTL and testbench

- Card-side counterpart of the host command controller. It sits on the serial CMD line of the SD bus model.
- Deserializes 48-bit host command frames and checks their format and CRC7.
- Exposes each decoded command, then serializes a 48-bit R1-style response back to the host after a fixed NCR gap.
- Used as the responder in host command-path benches and as the front end of the card model.

---
 rtl/cmd_card_responder.sv | 135 +++++++++++++
 tb/tb_cmd_card_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_card_responder.sv
// Card-side SD CMD-line responder: receives 48-bit host commands, checks format/CRC7,
// and answers valid commands with an R1-style response after an NCR gap.
module cmd_card_responder #(
  parameter int unsigned NCR = 2
) (
  input  logic        iClock_host,
  input  logic        iReset,
  input  logic        iCmd_in,
  input  logic [31:0] iCard_status,
  input  logic        iResp_enable,
  output logic        oCmd_out,
  output logic        oCmd_oe,
  output logic        oCmd_valid,
  output logic        oFrame_error,
  output logic [5:0]  oCmd_index,
  output logic [31:0] oCmd_argument,
  output logic        oBusy
);

  typedef enum logic [2:0] {IDLE, RX, CHECK, WAIT, TX} state_t;

  state_t      state, nextState;
  logic [46:0] rxShift;
  logic [6:0]  rxCrc;
  logic [5:0]  bitCnt;
  logic [6:0]  waitCnt;
  logic [47:0] txShift;
  logic [5:0]  txCnt;
  logic        cmdValid, frameError;
  logic [5:0]  cmdIndex;
  logic [31:0] cmdArgument;
  logic        frameOk;
  logic [39:0] respBody;
  logic [47:0] respFrame;

  function automatic logic [6:0] crc7Next(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int unsigned i = 0; i < 40; i++) c = crc7Next(c, d[39-i]);
    return c;
  endfunction

  // The start bit is never stored; rxShift holds frame bits 46:0.
  assign frameOk   = rxShift[46] & rxShift[0] & (rxShift[7:1] == rxCrc);
  assign respBody  = {2'b00, rxShift[45:40], iCard_status};
  assign respFrame = {respBody, crc7(respBody), 1'b1};

  always_ff @(posedge iClock_host or posedge iReset) begin
    if (iReset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (!iCmd_in) nextState = RX;
      RX:    if (bitCnt == 6'd47) nextState = CHECK;
      CHECK: nextState = (frameOk && iResp_enable) ? WAIT : IDLE;
      WAIT:  if (waitCnt == 7'(NCR - 1)) nextState = TX;
      TX:    if (txCnt == 6'd47) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClock_host or posedge iReset) begin
    if (iReset) begin
      rxShift     <= '0;
      rxCrc       <= '0;
      bitCnt      <= '0;
      waitCnt     <= '0;
      txShift     <= '1;
      txCnt       <= '0;
      cmdValid    <= 1'b0;
      frameError  <= 1'b0;
      cmdIndex    <= '0;
      cmdArgument <= '0;
    end else begin
      cmdValid   <= 1'b0;
      frameError <= 1'b0;
      unique case (state)
        IDLE: begin
          bitCnt <= 6'd1;
          rxCrc  <= '0;
        end
        RX: begin
          rxShift <= {rxShift[45:0], iCmd_in};
          bitCnt  <= bitCnt + 6'd1;
          // Bits 46..8 feed the CRC; the leading zero start bit leaves it at 0.
          if (bitCnt <= 6'd39) rxCrc <= crc7Next(rxCrc, iCmd_in);
        end
        CHECK: begin
          waitCnt <= '0;
          if (frameOk) begin
            cmdValid    <= 1'b1;
            cmdIndex    <= rxShift[45:40];
            cmdArgument <= rxShift[39:8];
            txShift     <= respFrame;
          end else begin
            frameError  <= 1'b1;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt + 7'd1;
          txCnt   <= '0;
        end
        TX: begin
          txShift <= {txShift[46:0], 1'b1};
          txCnt   <= txCnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    oCmd_out      = 1'b1;
    oCmd_oe       = 1'b0;
    oBusy         = (state != IDLE);
    oCmd_valid    = cmdValid;
    oFrame_error  = frameError;
    oCmd_index    = cmdIndex;
    oCmd_argument = cmdArgument;
    if (state == TX) begin
      oCmd_out = txShift[47];
      oCmd_oe  = 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_card_responder.sv
// Scoreboard bench for cmd_card_responder: expected pulses/responses are queued as
// frames are driven and compared when the DUT produces them.
module tb_cmd_card_responder;
  localparam int unsigned NCR = 2;
  localparam logic [47:0] CMD0      = 48'h400000000095;
  localparam logic [47:0] CMD17     = 48'h510000000055;
  localparam logic [47:0] CMD8      = 48'h48000001AA87;
  localparam logic [47:0] CMD8BADCRC = 48'h48000001AA85;
  localparam logic [47:0] CMD8NOEND = 48'h48000001AA86;
  localparam logic [47:0] CMD8NOTX  = 48'h08000001AA87;
  localparam logic [47:0] RESP17    = 48'h110000090067;

  logic        clk = 1'b0;
  logic        rst, cmdIn, respEn;
  logic [31:0] status;
  logic        oCmd_out, oCmd_oe, oCmd_valid, oFrame_error, oBusy;
  logic [5:0]  oCmd_index;
  logic [31:0] oCmd_argument;

  cmd_card_responder #(.NCR(NCR)) dut (
    .iClock_host(clk), .iReset(rst), .iCmd_in(cmdIn), .iCard_status(status),
    .iResp_enable(respEn), .oCmd_out(oCmd_out), .oCmd_oe(oCmd_oe),
    .oCmd_valid(oCmd_valid), .oFrame_error(oFrame_error), .oCmd_index(oCmd_index),
    .oCmd_argument(oCmd_argument), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct { bit good; logic [5:0] idx; logic [31:0] arg; int unsigned cyc; } ev_t;
  typedef struct { logic [47:0] bits; int unsigned cyc; } resp_t;
  ev_t   evQ[$];
  resp_t respQ[$];

  ev_t         evHead;
  resp_t       respHead;
  logic [5:0]  lastIdx = '0;
  logic [31:0] lastArg = '0;
  logic [47:0] rxBits = '0;
  int unsigned nBits = 0;
  int unsigned firstCyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      nBits   = 0;
      lastIdx = '0;
      lastArg = '0;
    end else begin
      chk("exclusivePulse", oCmd_valid & oFrame_error, 0);
      if (oCmd_valid || oFrame_error) begin
        chk("pulseExpected", evQ.size() != 0, 1);
        if (evQ.size() != 0) begin
          evHead = evQ.pop_front();
          chk("pulseKind", oCmd_valid, evHead.good);
          chk("pulseCycle", cyc, evHead.cyc);
          if (evHead.good) begin
            lastIdx = evHead.idx;
            lastArg = evHead.arg;
          end
          chk("cmdIndex", oCmd_index, lastIdx);
          chk("cmdArgument", oCmd_argument, lastArg);
        end
      end
      if (oCmd_oe) begin
        if (nBits == 0) firstCyc = cyc;
        rxBits = {rxBits[46:0], oCmd_out};
        nBits++;
        if (nBits == 48) begin
          chk("respExpected", respQ.size() != 0, 1);
          if (respQ.size() != 0) begin
            respHead = respQ.pop_front();
            chk("respBits", rxBits, respHead.bits);
            chk("respStartCycle", firstCyc, respHead.cyc);
          end
          nBits = 0;
        end
      end else begin
        chk("idleLine", oCmd_out, 1);
        chk("respLength", nBits, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBits(input logic [47:0] f, input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      cmdIn = f[47-i];
      tick();
    end
    cmdIn = 1'b1;
  endtask

  task automatic sendCmd(input logic [47:0] f, input bit good, input logic [47:0] resp);
    int unsigned k;
    sendBits(f, 48);
    k = cyc;
    evQ.push_back('{good: good, idx: f[45:40], arg: f[39:8], cyc: k + 1});
    if (good && respEn) respQ.push_back('{bits: resp, cyc: k + 1 + NCR});
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 300; i++) begin
      if (!oBusy) break;
      tick();
    end
    chk("idleTimeout", oBusy, 0);
  endtask

  task automatic checkReset();
    chk("rstCmdOut", oCmd_out, 1);
    chk("rstCmdOe", oCmd_oe, 0);
    chk("rstValid", oCmd_valid, 0);
    chk("rstError", oFrame_error, 0);
    chk("rstIndex", oCmd_index, 0);
    chk("rstArgument", oCmd_argument, 0);
    chk("rstBusy", oBusy, 0);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    respQ.delete();
    #1;
    checkReset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmdIn = 1'b1; respEn = 1'b0; status = '0;
    #12;
    checkReset();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("idleQuiet", oBusy, 0);

    // CMD0, no response
    sendCmd(CMD0, 1'b1, '0);
    chk("busyAtEnd", oBusy, 1);
    tick();
    tick();
    chk("busyK2", oBusy, 0);
    repeat (2) tick();

    // CMD17 with response
    respEn = 1'b1; status = 32'h00000900;
    sendCmd(CMD17, 1'b1, RESP17);
    waitIdle();
    repeat (2) tick();

    // CRC error, then end-bit and transmission-bit errors, then good CMD8 back to back
    sendCmd(CMD8BADCRC, 1'b0, '0);
    waitIdle();
    respEn = 1'b0;
    sendCmd(CMD8NOEND, 1'b0, '0);
    waitIdle();
    sendCmd(CMD8NOTX, 1'b0, '0);
    waitIdle();
    sendCmd(CMD8, 1'b1, '0);
    waitIdle();
    repeat (2) tick();

    // Start bit during TX is ignored; next CMD17 right after response end
    respEn = 1'b1;
    sendCmd(CMD17, 1'b1, RESP17);
    for (int i = 0; i < 20; i++) begin
      if (oCmd_oe) break;
      tick();
    end
    chk("txStartTimeout", oCmd_oe, 1);
    repeat (5) tick();
    cmdIn = 1'b0;
    tick();
    cmdIn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!oCmd_oe) break;
      tick();
    end
    chk("txEndTimeout", oCmd_oe, 0);
    sendCmd(CMD17, 1'b1, RESP17);
    waitIdle();
    repeat (2) tick();

    // Reset at RX bit 20, then CMD0
    respEn = 1'b0;
    sendBits(CMD17, 21);
    chk("busyMidRx", oBusy, 1);
    pulseReset();
    sendCmd(CMD0, 1'b1, '0);
    waitIdle();
    sendCmd(CMD8, 1'b1, '0);
    waitIdle();
    repeat (2) tick();

    // Reset at response bit 10, then CMD0
    respEn = 1'b1;
    sendCmd(CMD17, 1'b1, RESP17);
    for (int i = 0; i < 100; i++) begin
      if (nBits >= 10) break;
      tick();
    end
    chk("respBit10Timeout", nBits, 10);
    chk("oeMidResp", oCmd_oe, 1);
    pulseReset();
    respEn = 1'b0;
    sendCmd(CMD0, 1'b1, '0);
    waitIdle();
    repeat (5) tick();

    chk("pulsesOutstanding", evQ.size(), 0);
    chk("respOutstanding", respQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
